// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared types and constants for the step sequencer
// State encoding, history width and button debounce length.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STEP    = 3'd2,
    CAPTURE = 3'd3,
    WAIT    = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int HIST_W    = 16;
  localparam int MAX_DEPTH = 8;

  // About 10 ms of stable input at 100 MHz.
  localparam logic [19:0] DB_COUNT = 20'd1_000_000;

  function automatic logic [3:0] eff_len(input logic [3:0] len, input logic [3:0] depth);
    return ((len == 4'd0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - step button synchronizer, optional debounce, rising-edge detect
// STEP_DEBOUNCE_EN adds a stable-count debounce between synchronizer and edge detect.
module btn_edge
  import seq_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

`ifdef STEP_DEBOUNCE_EN
  logic        stable_q;
  logic [19:0] cnt_q;

  // The level only follows the synchronized input once it has differed for DB_COUNT cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= 20'd0;
    end else if (sync_q[1] == stable_q) begin
      cnt_q <= 20'd0;
    end else if (cnt_q == DB_COUNT - 20'd1) begin
      stable_q <= sync_q[1];
      cnt_q    <= 20'd0;
    end else begin
      cnt_q <= cnt_q + 20'd1;
    end
  end

  assign level = stable_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/step_seq_ctrl.sv
// rtl/step_seq_ctrl.sv - steps an external sequential circuit through a stored input pattern
// Manual (button) or automatic stepping; STEP_DEBOUNCE_EN enables button debounce in btn_edge.
module step_seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AUTO_DIV = 50_000_000
) (
  input  logic        CP,
  input  logic        CLR_n,
  input  logic        start,
  input  logic        mode,
  input  logic        step_btn,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [1:0]  wr_data,
  input  logic [3:0]  len,
  input  logic        y_in,
  input  logic        Z_in,
  output logic        x1,
  output logic        x2,
  output logic        step_en,
  output logic        busy,
  output logic        done,
  output logic [3:0]  step_cnt,
  output logic [15:0] hist
);

  localparam logic [3:0]  DEPTH_L  = 4'(DEPTH);
  localparam logic [31:0] DIV_LAST = 32'(AUTO_DIV - 1);

  state_e              state_q, state_d;
  logic [1:0]          pat_q [MAX_DEPTH];
  logic [3:0]          step_cnt_q;
  logic [3:0]          len_q;
  logic                mode_q;
  logic [HIST_W-1:0]   hist_q;
  logic [31:0]         div_q;
  logic                btn_rise;
  logic                accept_start;
  logic                drive_x;

  btn_edge u_btn_edge (
    .clk_i  (CP),
    .rst_ni (CLR_n),
    .btn_i  (step_btn),
    .rise_o (btn_rise)
  );

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP:   state_d = STEP;
      STEP:    state_d = CAPTURE;
      CAPTURE: state_d = (step_cnt_q + 4'd1 == len_q) ? DONE : WAIT;
      WAIT: begin
        if (mode_q ? (div_q == DIV_LAST) : btn_rise) begin
          state_d = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so an asynchronous clear takes effect at once.
  always_comb begin
    busy     = (state_q == SETUP) || (state_q == STEP) || (state_q == CAPTURE) || (state_q == WAIT);
    done     = (state_q == DONE);
    step_en  = (state_q == STEP);
    drive_x  = (state_q == SETUP) || (state_q == STEP) || (state_q == CAPTURE);
    {x1, x2} = drive_x ? pat_q[step_cnt_q[2:0]] : 2'b00;
  end

  assign step_cnt = step_cnt_q;
  assign hist     = hist_q;

  always_ff @(posedge CP or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q    <= IDLE;
      step_cnt_q <= 4'd0;
      len_q      <= 4'd0;
      mode_q     <= 1'b0;
      hist_q     <= '0;
      div_q      <= 32'd0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        pat_q[i] <= 2'b00;
      end
    end else begin
      state_q <= state_d;

      // Pattern is frozen while a sequence runs; a write alongside start lands first.
      if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L)) begin
        pat_q[wr_addr] <= wr_data;
      end

      if (state_q == IDLE || accept_start) begin
        step_cnt_q <= 4'd0;
        hist_q     <= '0;
        if (accept_start) begin
          mode_q <= mode;
          len_q  <= eff_len(len, DEPTH_L);
        end
      end else if (state_q == CAPTURE) begin
        hist_q[{step_cnt_q[2:0], 1'b0} +: 2] <= {y_in, Z_in};
        step_cnt_q <= step_cnt_q + 4'd1;
      end

      div_q <= (state_q == WAIT) ? div_q + 32'd1 : 32'd0;
    end
  end

endmodule

// File: tb/tb_step_seq_ctrl.sv
// tb/tb_step_seq_ctrl.sv - directed table-driven bench for step_seq_ctrl
module tb_step_seq_ctrl;

  logic        CP = 1'b0;
  logic        CLR_n = 1'b0;
  logic        start = 1'b0, mode = 1'b0, step_btn = 1'b0, wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [1:0]  wr_data = 2'd0;
  logic [3:0]  len = 4'd0;
  logic        y_in = 1'b0, Z_in = 1'b0;
  logic        x1, x2, step_en, busy, done;
  logic [3:0]  step_cnt;
  logic [15:0] hist;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0] x;
    logic       y;
    logic       z;
  } vec_t;

  vec_t tbl [8];

  step_seq_ctrl #(.DEPTH(8), .AUTO_DIV(4)) dut (
    .CP(CP), .CLR_n(CLR_n), .start(start), .mode(mode), .step_btn(step_btn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .len(len),
    .y_in(y_in), .Z_in(Z_in), .x1(x1), .x2(x2), .step_en(step_en),
    .busy(busy), .done(done), .step_cnt(step_cnt), .hist(hist)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge CP);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic m, input logic [3:0] l);
    start = 1'b1; mode = m; len = l;
    @(negedge CP);
    start = 1'b0;
  endtask

  task automatic count_pulses(input int cycles, output int p);
    p = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CP);
      if (step_en) p++;
    end
  endtask

  // Entered on the negedge after start was accepted; follows tbl for n steps until done.
  task automatic run_steps(input string tag, input int n, input int budget);
    int          pulses;
    logic [1:0]  prev_x;
    logic [15:0] eh;
    bit          finished;
    pulses   = 0;
    finished = 0;
    prev_x   = {x1, x2};
    eh       = 16'h0;
    for (int k = 0; k < n; k++) eh[2*k +: 2] = {tbl[k].y, tbl[k].z};
    for (int c = 0; c < budget; c++) begin
      @(negedge CP);
      if (step_en) begin
        if (pulses < 8) begin
          check({tag, "_x_at_pulse"}, {30'd0, x1, x2}, {30'd0, tbl[pulses].x});
          check({tag, "_x_setup"}, {30'd0, prev_x}, {30'd0, tbl[pulses].x});
          y_in = tbl[pulses].y;
          Z_in = tbl[pulses].z;
        end
        pulses++;
      end
      prev_x = {x1, x2};
      if (done) begin
        finished = 1;
        break;
      end
    end
    check({tag, "_finished"}, {31'd0, finished}, 32'd1);
    check({tag, "_pulses"}, pulses, n);
    check({tag, "_step_cnt"}, {28'd0, step_cnt}, n);
    check({tag, "_hist"}, {16'd0, hist}, {16'd0, eh});
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic manual_run(input logic [3:0] l);
    int p;
    pulse_start(1'b0, l);
    count_pulses(10, p);
    check("man_first_step", p, 1);
    check("man_cnt1", {28'd0, step_cnt}, 32'd1);
    check("man_busy_wait", {31'd0, busy}, 32'd1);
    pulse_start(1'b1, 4'd6);
    count_pulses(10, p);
    check("man_start_ignored", p, 0);
    for (int s = 1; s < int'(l); s++) begin
      step_btn = 1'b1;
      count_pulses(50, p);
      check("man_hold_one_step", p, 1);
      step_btn = 1'b0;
      count_pulses(5, p);
      check("man_release_no_step", p, 0);
      check("man_cnt", {28'd0, step_cnt}, s + 1);
    end
    check("man_done", {31'd0, done}, 32'd1);
    step_btn = 1'b1;
    count_pulses(10, p);
    step_btn = 1'b0;
    check("man_press_in_done", p, 0);
    check("man_cnt_final", {28'd0, step_cnt}, {28'd0, l});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;

    repeat (3) @(negedge CP);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_outs", {29'd0, x1, x2, step_en}, 32'd0);
    check("rst_cnt_hist", {12'd0, step_cnt, hist}, 32'd0);
    CLR_n = 1'b1;
    @(negedge CP);

    // Auto run over four entries, then y/Z history
    tbl[0] = '{2'b00, 1'b1, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 1'b1};
    tbl[2] = '{2'b10, 1'b1, 1'b1};
    tbl[3] = '{2'b11, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) wr(3'(i), tbl[i].x);
    pulse_start(1'b1, 4'd4);
    run_steps("auto4", 4, 200);
    check("auto4_hist_low", {28'd0, hist[3:0]}, 32'h6);

    // Manual stepping with a held button
    manual_run(4'd2);
    manual_run(4'd3);

    // Asynchronous clear while waiting after step 2 of 4
    wr(3'd0, 2'b11); wr(3'd1, 2'b10); wr(3'd2, 2'b01); wr(3'd3, 2'b11);
    y_in = 1'b1; Z_in = 1'b1;
    pulse_start(1'b0, 4'd4);
    count_pulses(10, p);
    step_btn = 1'b1;
    count_pulses(20, p);
    step_btn = 1'b0;
    count_pulses(5, p);
    check("pre_clr_cnt", {28'd0, step_cnt}, 32'd2);
    check("pre_clr_hist", {16'd0, hist}, 32'h000F);
    #2 CLR_n = 1'b0;
    #1;
    check("clr_x_en", {29'd0, x1, x2, step_en}, 32'd0);
    check("clr_busy_done", {30'd0, busy, done}, 32'd0);
    check("clr_cnt_hist", {12'd0, step_cnt, hist}, 32'd0);
    @(negedge CP);
    CLR_n = 1'b1;
    tbl[0] = '{2'b00, 1'b0, 1'b1};
    pulse_start(1'b1, 4'd1);
    check("post_clr_start_accepted", {31'd0, busy}, 32'd1);
    run_steps("post_clr", 1, 100);

    // len=0 -> 8 steps; write with start; unwritten entry 5; busy write ignored
    tbl[0] = '{2'b01, 1'b1, 1'b0};
    tbl[1] = '{2'b10, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 1'b1, 1'b1};
    tbl[3] = '{2'b01, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 1'b1, 1'b0};
    tbl[5] = '{2'b00, 1'b0, 1'b1};
    tbl[6] = '{2'b11, 1'b1, 1'b1};
    tbl[7] = '{2'b01, 1'b1, 1'b0};
    for (int i = 1; i < 8; i++) begin
      if (i != 5) wr(3'(i), tbl[i].x);
    end
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 2'b01;
    pulse_start(1'b1, 4'd0);
    wr_en = 1'b0;
    fork
      run_steps("len0_a", 8, 300);
      begin
        repeat (9) @(negedge CP);
        check("busy_during_write", {31'd0, busy}, 32'd1);
        wr(3'd0, 2'b11);
      end
    join
    pulse_start(1'b1, 4'd0);
    run_steps("len0_rerun", 8, 300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
